// File: rtl/lock_pkg.sv
// Shared types, default parameters and digit-extraction helper for the
// sequential code lock.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } lock_state_e;

  localparam int          DEF_DIGIT_W        = 4;
  localparam int          DEF_CODE_LEN       = 4;
  localparam int          DEF_MAX_TRIES      = 3;
  localparam int          DEF_UNLOCK_CYCLES  = 8;
  localparam int          DEF_LOCKOUT_CYCLES = 16;
  localparam logic [15:0] DEF_RESET_CODE     = 16'h1234;

  // Widest code the helper accepts; callers zero-extend into this width.
  localparam int MAX_CODE_W = 256;

  // Digit k of a packed code, where digit 0 sits in the most significant bits.
  function automatic logic [31:0] code_digit(input logic [MAX_CODE_W-1:0] code,
                                             input int code_len,
                                             input int digit_w,
                                             input int k);
    logic [MAX_CODE_W-1:0] mask;
    mask = (MAX_CODE_W'(1) << digit_w) - MAX_CODE_W'(1);
    return 32'((code >> ((code_len - 1 - k) * digit_w)) & mask);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the open window and the lockout period;
// done marks the final cycle (count of 1). It stops at zero rather than wrapping.
module lock_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/sequential_code_lock.sv
// Multi-digit code lock: per-digit comparison, timed open window, failed-attempt
// counting and timed lockout with alarm. All outputs come straight from registers.
module sequential_code_lock
  import lock_pkg::*;
#(
  parameter int DIGIT_W        = DEF_DIGIT_W,
  parameter int CODE_LEN       = DEF_CODE_LEN,
  parameter int MAX_TRIES      = DEF_MAX_TRIES,
  parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter logic [CODE_LEN*DIGIT_W-1:0] RESET_CODE = DEF_RESET_CODE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             digit_valid,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             entry_clr,
  input  logic                             code_load,
  input  logic [CODE_LEN*DIGIT_W-1:0]      code_in,
  output logic                             unlocked,
  output logic                             alarm,
  output logic                             attempt_fail,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

  localparam int CODE_W  = CODE_LEN * DIGIT_W;
  localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int FAIL_W  = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_TRIES);

  lock_state_e        r_state, w_state_next;
  logic [IDX_W-1:0]   r_idx, w_idx_next;
  logic               r_err, w_err_next;
  logic [FAIL_W-1:0]  r_fail_cnt, w_fail_next;
  logic [CODE_W-1:0]  r_code, w_code_next;
  logic               r_unlocked, r_alarm, r_attempt_fail, w_attempt_fail_next;
  logic [FAIL_W-1:0]  r_tries_left;

  logic               w_tmr_load, w_tmr_done;
  logic [TMR_W-1:0]   w_tmr_val;
  logic [DIGIT_W-1:0] w_expected;
  logic               w_err_now;

  assign w_expected = DIGIT_W'(code_digit(MAX_CODE_W'(r_code), CODE_LEN, DIGIT_W, int'(r_idx)));
  assign w_err_now  = r_err | (digit != w_expected);

  lock_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  always_comb begin
    w_state_next        = r_state;
    w_idx_next          = r_idx;
    w_err_next          = r_err;
    w_fail_next         = r_fail_cnt;
    w_code_next         = r_code;
    w_attempt_fail_next = 1'b0;
    w_tmr_load          = 1'b0;
    w_tmr_val           = '0;
    unique case (r_state)
      ST_ENTRY: begin
        if (entry_clr) begin
          w_idx_next = '0;
          w_err_next = 1'b0;
        end else if (digit_valid) begin
          if (r_idx == LAST_IDX) begin
            w_idx_next = '0;
            w_err_next = 1'b0;
            if (!w_err_now) begin
              w_state_next = ST_OPEN;
              w_fail_next  = '0;
              w_tmr_load   = 1'b1;
              w_tmr_val    = TMR_W'(UNLOCK_CYCLES);
            end else begin
              w_attempt_fail_next = 1'b1;
              // fail_cnt is always below MAX_TRIES while in ENTRY, so this saturates at MAX_TRIES
              w_fail_next = r_fail_cnt + FAIL_W'(1);
              if (w_fail_next == FAIL_MAX) begin
                w_state_next = ST_LOCKOUT;
                w_tmr_load   = 1'b1;
                w_tmr_val    = TMR_W'(LOCKOUT_CYCLES);
              end
            end
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
            w_err_next = w_err_now;
          end
        end
      end
      ST_OPEN: begin
        if (code_load) begin
          w_code_next  = code_in;
          w_state_next = ST_ENTRY;
        end else if (w_tmr_done) begin
          w_state_next = ST_ENTRY;
        end
      end
      ST_LOCKOUT: begin
        if (w_tmr_done) begin
          w_state_next = ST_ENTRY;
          w_fail_next  = '0;
        end
      end
      default: w_state_next = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_ENTRY;
      r_idx          <= '0;
      r_err          <= 1'b0;
      r_fail_cnt     <= '0;
      r_code         <= RESET_CODE;
      r_unlocked     <= 1'b0;
      r_alarm        <= 1'b0;
      r_attempt_fail <= 1'b0;
      r_tries_left   <= FAIL_MAX;
    end else begin
      r_state        <= w_state_next;
      r_idx          <= w_idx_next;
      r_err          <= w_err_next;
      r_fail_cnt     <= w_fail_next;
      r_code         <= w_code_next;
      r_unlocked     <= (w_state_next == ST_OPEN);
      r_alarm        <= (w_state_next == ST_LOCKOUT);
      r_attempt_fail <= w_attempt_fail_next;
      r_tries_left   <= FAIL_MAX - w_fail_next;
    end
  end

  assign unlocked     = r_unlocked;
  assign alarm        = r_alarm;
  assign attempt_fail = r_attempt_fail;
  assign tries_left   = r_tries_left;

endmodule

// File: tb/tb_sequential_code_lock.sv
// Directed bench for sequential_code_lock: a table of per-cycle input/expected
// output records, plus hand-written reset-in-OPEN and reset-in-LOCKOUT sequences.
module tb_sequential_code_lock;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = '0;
  logic        entry_clr = 1'b0;
  logic        code_load = 1'b0;
  logic [15:0] code_in = '0;
  logic        unlocked, alarm, attempt_fail;
  logic [1:0]  tries_left;

  typedef struct {
    logic        rst;
    logic        dv;
    logic [3:0]  d;
    logic        clr;
    logic        ld;
    logic [15:0] cin;
    logic        eu;
    logic        ea;
    logic        ef;
    logic [1:0]  et;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_no   = 0;

  sequential_code_lock dut (
    .clk          (clk),
    .rst          (rst),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .entry_clr    (entry_clr),
    .code_load    (code_load),
    .code_in      (code_in),
    .unlocked     (unlocked),
    .alarm        (alarm),
    .attempt_fail (attempt_fail),
    .tries_left   (tries_left)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic dv, input logic [3:0] d,
                              input logic clr, input logic ld, input logic [15:0] cin,
                              input logic eu, input logic ea, input logic ef,
                              input logic [1:0] et);
    vec_t v;
    v.rst = r; v.dv = dv; v.d = d; v.clr = clr; v.ld = ld; v.cin = cin;
    v.eu = eu; v.ea = ea; v.ef = ef; v.et = et;
    return v;
  endfunction

  function automatic void add(input vec_t v);
    vecs.push_back(v);
  endfunction

  function automatic void idle(input int n, input logic eu, input logic ea, input logic [1:0] et);
    for (int i = 0; i < n; i++) add(mk(0, 0, 4'h0, 0, 0, 16'h0, eu, ea, 0, et));
  endfunction

  function automatic void key(input logic [3:0] d, input logic eu, input logic ea, input logic [1:0] et);
    add(mk(0, 1, d, 0, 0, 16'h0, eu, ea, 0, et));
  endfunction

  // Four digits from ENTRY; only the last strobe changes the outputs.
  function automatic void attempt(input logic [15:0] c, input logic eu, input logic ea,
                                  input logic ef, input logic [1:0] et, input logic [1:0] et_before);
    key(c[15:12], 0, 0, et_before);
    key(c[11:8],  0, 0, et_before);
    key(c[7:4],   0, 0, et_before);
    add(mk(0, 1, c[3:0], 0, 0, 16'h0, eu, ea, ef, et));
  endfunction

  task automatic check(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL vec %0d %s: got %0h, expected %0h", id, nm, act, exp);
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; digit_valid = v.dv; digit = v.d; entry_clr = v.clr;
    code_load = v.ld; code_in = v.cin;
    @(posedge clk);
    #1;
    check(vec_no, "unlocked",     32'(unlocked),     32'(v.eu));
    check(vec_no, "alarm",        32'(alarm),        32'(v.ea));
    check(vec_no, "attempt_fail", 32'(attempt_fail), 32'(v.ef));
    check(vec_no, "tries_left",   32'(tries_left),   32'(v.et));
    $display("vec %0d: rst=%b dv=%b d=%h clr=%b ld=%b cin=%h -> u=%b a=%b f=%b t=%0d",
             vec_no, v.rst, v.dv, v.d, v.clr, v.ld, v.cin, unlocked, alarm, attempt_fail, tries_left);
    vec_no++;
  endtask

  task automatic hand_attempt(input logic [15:0] c, input logic eu, input logic ea,
                              input logic ef, input logic [1:0] et, input logic [1:0] et_before);
    apply(mk(0, 1, c[15:12], 0, 0, 16'h0, 0, 0, 0, et_before));
    apply(mk(0, 1, c[11:8],  0, 0, 16'h0, 0, 0, 0, et_before));
    apply(mk(0, 1, c[7:4],   0, 0, 16'h0, 0, 0, 0, et_before));
    apply(mk(0, 1, c[3:0],   0, 0, 16'h0, eu, ea, ef, et));
  endtask

  initial begin
    // Reset state
    add(mk(1, 0, 4'h0, 0, 0, 16'h0, 0, 0, 0, 2'd3));
    idle(1, 0, 0, 2'd3);
    // Correct code: open exactly 8 cycles
    attempt(16'h1234, 1, 0, 0, 2'd3, 2'd3);
    idle(7, 1, 0, 2'd3);
    idle(2, 0, 0, 2'd3);
    // One wrong digit, then correct code restores tries
    attempt(16'h1294, 0, 0, 1, 2'd2, 2'd3);
    idle(1, 0, 0, 2'd2);
    attempt(16'h1234, 1, 0, 0, 2'd3, 2'd2);
    idle(7, 1, 0, 2'd3);
    idle(1, 0, 0, 2'd3);
    // Three failures -> 16-cycle lockout; keys and code_load ignored meanwhile
    attempt(16'h0000, 0, 0, 1, 2'd2, 2'd3);
    attempt(16'h0000, 0, 0, 1, 2'd1, 2'd2);
    attempt(16'h0000, 0, 1, 1, 2'd0, 2'd1);
    key(4'h1, 0, 1, 2'd0);
    key(4'h2, 0, 1, 2'd0);
    key(4'h3, 0, 1, 2'd0);
    key(4'h4, 0, 1, 2'd0);
    add(mk(0, 0, 4'h0, 0, 1, 16'hA5C0, 0, 1, 0, 2'd0));
    idle(10, 0, 1, 2'd0);
    idle(1, 0, 0, 2'd3);
    attempt(16'h1234, 1, 0, 0, 2'd3, 2'd3);
    idle(7, 1, 0, 2'd3);
    idle(1, 0, 0, 2'd3);
    // entry_clr beats a simultaneous digit and is not a failure
    key(4'h1, 0, 0, 2'd3);
    key(4'h2, 0, 0, 2'd3);
    add(mk(0, 1, 4'h3, 1, 0, 16'h0, 0, 0, 0, 2'd3));
    attempt(16'h1234, 1, 0, 0, 2'd3, 2'd3);
    // While open: digits ignored, code_load closes and replaces the code
    key(4'h5, 1, 0, 2'd3);
    add(mk(0, 0, 4'h0, 0, 1, 16'hA5C0, 0, 0, 0, 2'd3));
    attempt(16'h1234, 0, 0, 1, 2'd2, 2'd3);
    idle(1, 0, 0, 2'd2);
    attempt(16'hA5C0, 1, 0, 0, 2'd3, 2'd2);
    idle(7, 1, 0, 2'd3);
    idle(1, 0, 0, 2'd3);
    // code_load in ENTRY has no effect
    add(mk(0, 0, 4'h0, 0, 1, 16'h1111, 0, 0, 0, 2'd3));
    attempt(16'hA5C0, 1, 0, 0, 2'd3, 2'd3);
    idle(7, 1, 0, 2'd3);
    idle(1, 0, 0, 2'd3);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset in the middle of the open window restores the reset code
    hand_attempt(16'hA5C0, 1, 0, 0, 2'd3, 2'd3);
    apply(mk(0, 0, 4'h0, 0, 0, 16'h0, 1, 0, 0, 2'd3));
    apply(mk(0, 0, 4'h0, 0, 0, 16'h0, 1, 0, 0, 2'd3));
    apply(mk(1, 0, 4'h0, 0, 0, 16'h0, 0, 0, 0, 2'd3));
    hand_attempt(16'hA5C0, 0, 0, 1, 2'd2, 2'd3);
    hand_attempt(16'h1234, 1, 0, 0, 2'd3, 2'd2);

    // Reset in the middle of lockout
    apply(mk(1, 0, 4'h0, 0, 0, 16'h0, 0, 0, 0, 2'd3));
    hand_attempt(16'h0000, 0, 0, 1, 2'd2, 2'd3);
    hand_attempt(16'h0000, 0, 0, 1, 2'd1, 2'd2);
    hand_attempt(16'h0000, 0, 1, 1, 2'd0, 2'd1);
    for (int i = 0; i < 3; i++) apply(mk(0, 0, 4'h0, 0, 0, 16'h0, 0, 1, 0, 2'd0));
    apply(mk(1, 0, 4'h0, 0, 0, 16'h0, 0, 0, 0, 2'd3));
    apply(mk(0, 0, 4'h0, 0, 0, 16'h0, 0, 0, 0, 2'd3));
    hand_attempt(16'h1234, 1, 0, 0, 2'd3, 2'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sequential_code_lock.md
Name: sequential_code_lock

Overview:
- Parametrised successor to the team's single-shot combinational lock.
- Checks a sequence of CODE_LEN digits, entered one per strobe, against a stored code.
- Holds `unlocked` for a fixed open window, counts failed attempts, and enters a timed lockout with alarm after MAX_TRIES failures.
- The stored code can be reprogrammed only while open. The block sits between the keypad decoder and the actuator driver.

Parameters:
- DIGIT_W, 4, bits per digit.
- CODE_LEN, 4, digits per code (>=1).
- MAX_TRIES, 3, consecutive failed attempts before lockout (>=1).
- UNLOCK_CYCLES, 8, clock cycles `unlocked` stays high (>=1).
- LOCKOUT_CYCLES, 16, clock cycles lockout lasts (>=1).
- RESET_CODE, 16'h1234, code value after reset (CODE_LEN*DIGIT_W bits).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- digit_valid  in  1  one-cycle strobe: `digit` is a new keypress.
- digit  in  DIGIT_W  entered digit value.
- entry_clr  in  1  abort partial entry; does not count as a failure.
- code_load  in  1  write `code_in` as the new stored code (honoured only in OPEN).
- code_in  in  CODE_LEN*DIGIT_W  new code; first digit in the MS DIGIT_W bits.
- unlocked  out  1  lock open.
- alarm  out  1  high throughout lockout.
- attempt_fail  out  1  one-cycle pulse on every failed attempt.
- tries_left  out  $clog2(MAX_TRIES+1)  failures remaining before lockout.

Behaviour:
- Reset values (rst sampled high at an edge):
  - state=ENTRY, idx=0, err=0, fail_cnt=0, stored code=RESET_CODE.
  - unlocked=0, alarm=0, attempt_fail=0, tries_left=MAX_TRIES.
  - Reset overrides all inputs and aborts any state, including OPEN and LOCKOUT.
- Digit order: the k-th entered digit (k=0..CODE_LEN-1) is compared to code[(CODE_LEN-k)*DIGIT_W-1 -: DIGIT_W].
- States: ENTRY, OPEN, LOCKOUT. All outputs are registered.
- ENTRY, on digit_valid:
  - err <= err | (digit != expected).
  - If idx < CODE_LEN-1: idx++.
  - Else (final digit) the attempt is evaluated that edge; idx and err are cleared.
  - Match (err==0 and final digit equal): next state OPEN, unlocked=1 from the next cycle (latency 1 cycle after the final strobe), fail_cnt=0.
  - Mismatch: attempt_fail pulses next cycle, fail_cnt++.
  - If fail_cnt reaches MAX_TRIES: next state LOCKOUT, alarm=1 next cycle. Otherwise stay in ENTRY.
- ENTRY, on entry_clr: idx=0, err=0, fail_cnt unchanged. entry_clr wins over a simultaneous digit_valid; that digit is discarded.
- OPEN:
  - unlocked=1 for exactly UNLOCK_CYCLES cycles, then ENTRY with unlocked=0.
  - digit_valid and entry_clr are ignored.
  - code_load: stored code <= code_in, immediate return to ENTRY (unlocked=0 next cycle). The new code applies to the next attempt.
- LOCKOUT:
  - alarm=1 for exactly LOCKOUT_CYCLES cycles, then ENTRY with fail_cnt=0 and tries_left=MAX_TRIES.
  - digit_valid, entry_clr and code_load are ignored; no partial digits are retained.
- code_load outside OPEN has no effect.
- tries_left = MAX_TRIES - fail_cnt, updated the same cycle as attempt_fail.
- A successful unlock restores tries_left=MAX_TRIES.
- Timer: a single down-counter, width $clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES)+1).
  - Loaded on entry to OPEN or LOCKOUT; the state exits when it reaches 1.
  - No wrap-around is permitted.
- idx width: $clog2(CODE_LEN) (min 1). fail_cnt saturates at MAX_TRIES.

Decomposition:
- Shared package lock_pkg:
  - state enum (ENTRY, OPEN, LOCKOUT).
  - Default parameter constants.
  - Helper function extracting digit k from a packed code.
- One natural sub-module: lock_timer, a loadable down-counter with a `done` output. It is shared by OPEN and LOCKOUT.
- Comparison and FSM stay in the top module.

Test Plan:
- Reset, then digits 1,2,3,4 strobed on consecutive cycles -> unlocked=1 the cycle after the '4', high for exactly 8 cycles, then 0; tries_left stays 3.
- Digits 1,2,9,4 -> no unlock, attempt_fail pulse one cycle after the '4', tries_left=2. Then 1,2,3,4 -> unlock, tries_left=3.
- Three wrong codes (e.g. 0,0,0,0 x3) -> third attempt_fail coincides with alarm=1 for 16 cycles. Strobing 1,2,3,4 during lockout leaves unlocked=0. After lockout, tries_left=3 and 1,2,3,4 unlocks.
- Digits 1,2 then entry_clr together with digit 3, then 1,2,3,4 -> unlocks, no attempt_fail, tries_left=3.
- While OPEN: code_load with code_in=16'hA5C0 -> unlocked=0 next cycle; 1,2,3,4 then fails; A,5,C,0 then unlocks. code_load during ENTRY leaves the code unchanged.
- rst asserted mid-OPEN and mid-LOCKOUT -> next cycle unlocked=0, alarm=0, tries_left=3, code back to 16'h1234.
